// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the fetch stage and its neighbours.
//   fetch_state_t    : fetch FSM encoding (IDLE/REQ/WAIT/HOLD)
//   NOP_INSTR        : instruction word presented while nothing has been fetched
//   RESET_PC_DEFAULT : default PC loaded on reset
// No ports (package).
// ----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// Bus interfaces of the fetch stage.
//   imem_if   : instruction-memory request/grant/response channel
//               master = fetch unit (drives imem_req, imem_addr)
//               slave  = memory     (drives imem_gnt, imem_rvalid, imem_rdata)
//   decode_if : fetch-to-decode channel plus the redirect from execute
//               master = fetch unit (drives instr_valid, Instr, PC, PCPlus4)
//               slave  = decode/execute (drives instr_ready, PCSrc, PCTarget)
// ----------------------------------------------------------------------------
interface imem_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

interface decode_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] Instr;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic            PCSrc;
    logic [XLEN-1:0] PCTarget;

    modport master (
        output instr_valid, Instr, PC, PCPlus4,
        input  instr_ready, PCSrc, PCTarget
    );

    modport slave (
        input  instr_valid, Instr, PC, PCPlus4,
        output instr_ready, PCSrc, PCTarget
    );
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// ----------------------------------------------------------------------------
// pc_reg
// Program counter with next-PC selection.
//   clk        : core clock, rising edge
//   rst        : asynchronous active-low reset, loads RESET_PC
//   load       : update the PC this cycle
//   sel_target : choose the redirect target instead of PC+4
//   target     : redirect target (low two bits are dropped)
//   pc         : current PC
//   pc_plus4   : pc + 4, wrapping modulo 2^XLEN
// ----------------------------------------------------------------------------
module pc_reg
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            sel_target,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic [XLEN-1:0] pc_next;

    assign pc_plus4 = pc + XLEN'(4);

    // A misaligned target is forced onto a word boundary rather than trapping.
    always_comb begin
        pc_next = sel_target ? (target & ~XLEN'(3)) : pc_plus4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: holds the PC, issues one word request at a time to instruction
// memory, latches the returned word and offers it to decode.
//   clk   : core clock, rising edge
//   rst   : asynchronous active-low reset
//   imem  : imem_if.master   (imem_req/imem_addr out, imem_gnt/rvalid/rdata in)
//   dec   : decode_if.master (instr_valid/Instr/PC/PCPlus4 out,
//                             instr_ready/PCSrc/PCTarget in)
//   fetch_cnt, stall_cnt : performance counters, present only when the macro
//                          IFU_PERF_CNT_EN is defined
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    imem_if.master      imem,
    decode_if.master    dec
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr_q;
    logic            handshake;
    logic            rvalid_take;

    assign handshake   = (state == HOLD) && dec.instr_ready;
    // Responses outside WAIT (including a gnt+rvalid collision in REQ and
    // stale responses after reset) never reach the instruction latch.
    assign rvalid_take = (state == WAIT) && imem.imem_rvalid;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (handshake),
        .sel_target (dec.PCSrc),
        .target     (dec.PCTarget),
        .pc         (pc_q),
        .pc_plus4   (pc_plus4)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a handshake goes straight back to REQ so the next
    // request issues in the following cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = REQ;
            REQ:     if (imem.imem_gnt)    state_next = WAIT;
            WAIT:    if (imem.imem_rvalid) state_next = HOLD;
            HOLD:    if (dec.instr_ready)  state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode from the state register only, so instr_ready has no
    // combinational path to imem_req.
    always_comb begin
        imem.imem_req   = 1'b0;
        dec.instr_valid = 1'b0;
        case (state)
            REQ:     imem.imem_req   = 1'b1;
            HOLD:    dec.instr_valid = 1'b1;
            default: ;
        endcase
    end

    assign imem.imem_addr = pc_q;
    assign dec.PC         = pc_q;
    assign dec.PCPlus4    = pc_plus4;
    assign dec.Instr      = instr_q;

    // Instruction latch; shows a NOP until the first word arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= XLEN'(NOP_INSTR);
        end else if (rvalid_take) begin
            instr_q <= imem.imem_rdata;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic stall_now;

    assign stall_now = ((state == REQ)  && !imem.imem_gnt)    ||
                       ((state == WAIT) && !imem.imem_rvalid) ||
                       ((state == HOLD) && !dec.instr_ready);

    // Fetch and stall counters, both free-running and wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (handshake) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall_now) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. Two instances share clock and
// reset: dut starts at PC 0, dut_wrap starts at 32'hFFFF_FFFC. Expected
// {PC, Instr} pairs are queued when a request is served and popped when
// instr_valid appears. Define IFU_PERF_CNT_EN to also check the counters.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import core_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   valid_cycle = 0;
    logic [31:0] next_pc = 32'd0;
    exp_t sb[$];

    imem_if   imem ();
    decode_if dec ();
    imem_if   imem2 ();
    decode_if dec2 ();

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt, fetch_cnt2, stall_cnt2;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (imem),
        .dec       (dec)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk       (clk),
        .rst       (rst),
        .imem      (imem2),
        .dec       (dec2)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt2),
        .stall_cnt (stall_cnt2)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'd0;
        dec.instr_ready  = 1'b0;
        dec.PCSrc        = 1'b0;
        dec.PCTarget     = 32'd0;
        imem2.imem_gnt    = 1'b0;
        imem2.imem_rvalid = 1'b0;
        imem2.imem_rdata  = 32'd0;
        dec2.instr_ready  = 1'b0;
        dec2.PCSrc        = 1'b0;
        dec2.PCTarget     = 32'd0;
    endtask

    // One complete fetch on dut with configurable stalls. noise=1 adds an
    // rvalid alongside gnt, PCSrc pulses in WAIT/HOLD and rvalid in HOLD,
    // all of which must be ignored.
    task automatic do_fetch(input logic [31:0] word, input int gw, input int rw,
                            input int yw, input logic src, input logic [31:0] tgt,
                            input logic noise);
        int n;
        exp_t e;
        logic [31:0] a;
        n = 0;
        while (imem.imem_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        total++;
        if (imem.imem_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL req_timeout actual=%b required=1", imem.imem_req);
            return;
        end
        total++;
        if (imem.imem_addr !== next_pc) begin
            bad++;
            $display("[TB] FAIL fetch_addr actual=%h required=%h", imem.imem_addr, next_pc);
        end
        e.pc = next_pc;
        e.instr = word;
        sb.push_back(e);
        a = imem.imem_addr;
        for (int i = 0; i < gw; i++) begin
            step();
            total++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== a) begin
                bad++;
                $display("[TB] FAIL req_hold actual=%b/%h required=1/%h",
                         imem.imem_req, imem.imem_addr, a);
            end
        end
        imem.imem_gnt = 1'b1;
        if (noise) begin
            imem.imem_rvalid = 1'b1;
            imem.imem_rdata  = 32'hBAD0_0001;
        end
        step();
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'd0;
        total++;
        if (imem.imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL req_drop actual=%b required=0", imem.imem_req);
        end
        for (int i = 0; i < rw; i++) begin
            if (noise) begin
                dec.PCSrc    = 1'b1;
                dec.PCTarget = 32'h0000_0100;
            end
            step();
            total++;
            if (dec.instr_valid !== 1'b0 || imem.imem_req !== 1'b0) begin
                bad++;
                $display("[TB] FAIL wait_state actual=%b/%b required=0/0",
                         dec.instr_valid, imem.imem_req);
            end
        end
        dec.PCSrc        = 1'b0;
        dec.PCTarget     = 32'd0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = word;
        step();
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'd0;
        valid_cycle = cycle;
        total++;
        if (dec.instr_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL valid_rise actual=%b required=1", dec.instr_valid);
        end
        e = sb.pop_front();
        total++;
        if (dec.Instr !== e.instr || dec.PC !== e.pc || dec.PCPlus4 !== e.pc + 32'd4) begin
            bad++;
            $display("[TB] FAIL hold_data actual=%h/%h/%h required=%h/%h/%h",
                     dec.Instr, dec.PC, dec.PCPlus4, e.instr, e.pc, e.pc + 32'd4);
        end
        for (int i = 0; i < yw; i++) begin
            if (noise) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = 32'hBAD0_0002;
                dec.PCSrc        = 1'b1;
                dec.PCTarget     = 32'h0000_0200;
            end
            step();
            total++;
            if (dec.instr_valid !== 1'b1 || imem.imem_req !== 1'b0 ||
                dec.Instr !== e.instr || dec.PC !== e.pc) begin
                bad++;
                $display("[TB] FAIL hold_stable actual=%b/%b/%h/%h required=1/0/%h/%h",
                         dec.instr_valid, imem.imem_req, dec.Instr, dec.PC, e.instr, e.pc);
            end
        end
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'd0;
        dec.instr_ready  = 1'b1;
        dec.PCSrc        = src;
        dec.PCTarget     = tgt;
        step();
        dec.instr_ready = 1'b0;
        dec.PCSrc       = 1'b0;
        dec.PCTarget    = 32'd0;
        next_pc = src ? {tgt[31:2], 2'b00} : e.pc + 32'd4;
        total++;
        if (dec.instr_valid !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== next_pc) begin
            bad++;
            $display("[TB] FAIL next_req actual=%b/%b/%h required=0/1/%h",
                     dec.instr_valid, imem.imem_req, imem.imem_addr, next_pc);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        step();
        step();
        sb.delete();
        next_pc = 32'd0;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        total++;
        if (imem.imem_req !== 1'b0 || dec.instr_valid !== 1'b0 || dec.Instr !== 32'h0000_0013) begin
            bad++;
            $display("[TB] FAIL reset_state actual=%b/%b/%h required=0/0/00000013",
                     imem.imem_req, dec.instr_valid, dec.Instr);
        end
        rst = 1'b1;
        #1;
        total++;
        if (imem.imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_cycle actual=%b required=0", imem.imem_req);
        end
        step();
        total++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'd0) begin
            bad++;
            $display("[TB] FAIL first_req actual=%b/%h required=1/00000000",
                     imem.imem_req, imem.imem_addr);
        end
        // Asynchronous assertion: no clock edge between assert and check.
        rst = 1'b0;
        #1;
        total++;
        if (imem.imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset actual=%b required=0", imem.imem_req);
        end
        step();
        rst = 1'b1;
        next_pc = 32'd0;
        step();
    endtask

    task automatic test_zero_wait();
        logic [31:0] words [3];
        int vc [3];
        words[0] = 32'h0050_0093;
        words[1] = 32'h00a0_0113;
        words[2] = 32'h0020_81b3;
        for (int i = 0; i < 3; i++) begin
            do_fetch(words[i], 0, 0, 0, 1'b0, 32'd0, 1'b0);
            vc[i] = valid_cycle;
        end
        for (int i = 1; i < 3; i++) begin
            total++;
            if (vc[i] - vc[i-1] !== 3) begin
                bad++;
                $display("[TB] FAIL throughput actual=%0d required=3", vc[i] - vc[i-1]);
            end
        end
    endtask

    task automatic test_stalls();
`ifdef IFU_PERF_CNT_EN
        logic [31:0] s0, f0;
        s0 = stall_cnt;
        f0 = fetch_cnt;
`endif
        do_fetch(32'h4000_0033, 4, 2, 5, 1'b0, 32'd0, 1'b0);
`ifdef IFU_PERF_CNT_EN
        total++;
        if (stall_cnt - s0 !== 32'd11) begin
            bad++;
            $display("[TB] FAIL stall_cnt actual=%0d required=11", stall_cnt - s0);
        end
        total++;
        if (fetch_cnt - f0 !== 32'd1) begin
            bad++;
            $display("[TB] FAIL fetch_cnt actual=%0d required=1", fetch_cnt - f0);
        end
`endif
    endtask

    task automatic test_redirect();
        apply_reset();
        do_fetch(32'h0000_0113, 0, 0, 0, 1'b0, 32'd0, 1'b0);
        do_fetch(32'h0000_0193, 0, 2, 2, 1'b0, 32'd0, 1'b1);
        do_fetch(32'h0000_0213, 0, 0, 0, 1'b1, 32'h0000_0043, 1'b0);
        total++;
        if (imem.imem_addr !== 32'h0000_0040) begin
            bad++;
            $display("[TB] FAIL redirect_addr actual=%h required=00000040", imem.imem_addr);
        end
        do_fetch(32'h0000_0293, 1, 1, 1, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_wrap();
        total++;
        if (imem2.imem_req !== 1'b1 || imem2.imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("[TB] FAIL wrap_req actual=%b/%h required=1/fffffffc",
                     imem2.imem_req, imem2.imem_addr);
        end
        imem2.imem_gnt = 1'b1;
        step();
        imem2.imem_gnt    = 1'b0;
        imem2.imem_rvalid = 1'b1;
        imem2.imem_rdata  = 32'h0000_0513;
        step();
        imem2.imem_rvalid = 1'b0;
        total++;
        if (dec2.instr_valid !== 1'b1 || dec2.PC !== 32'hFFFF_FFFC ||
            dec2.PCPlus4 !== 32'd0 || dec2.Instr !== 32'h0000_0513) begin
            bad++;
            $display("[TB] FAIL wrap_hold actual=%b/%h/%h/%h required=1/fffffffc/00000000/00000513",
                     dec2.instr_valid, dec2.PC, dec2.PCPlus4, dec2.Instr);
        end
        dec2.instr_ready = 1'b1;
        step();
        dec2.instr_ready = 1'b0;
        total++;
        if (imem2.imem_req !== 1'b1 || imem2.imem_addr !== 32'd0) begin
            bad++;
            $display("[TB] FAIL wrap_next actual=%b/%h required=1/00000000",
                     imem2.imem_req, imem2.imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (imem.imem_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (imem.imem_req !== 1'b0 || dec.instr_valid !== 1'b0 || dec.Instr !== 32'h0000_0013) begin
            bad++;
            $display("[TB] FAIL mid_reset actual=%b/%b/%h required=0/0/00000013",
                     imem.imem_req, dec.instr_valid, dec.Instr);
        end
        step();
        rst = 1'b1;
        sb.delete();
        next_pc = 32'd0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hDEAD_BEEF;
        step();
        step();
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'd0;
        total++;
        if (dec.instr_valid !== 1'b0 || dec.Instr !== 32'h0000_0013 ||
            imem.imem_req !== 1'b1 || imem.imem_addr !== 32'd0) begin
            bad++;
            $display("[TB] FAIL late_rvalid actual=%b/%h/%b/%h required=0/00000013/1/00000000",
                     dec.instr_valid, dec.Instr, imem.imem_req, imem.imem_addr);
        end
        do_fetch(32'h0010_0093, 0, 0, 0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stalls();
        test_redirect();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit/decoder.
- Holds the PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, and captures the returned instruction.
- Presents Instr, PC and PCPlus4 to decode with a valid/ready handshake. Instr[6:0], Instr[14:12] and Instr[31:25] feed the control unit's Op, funct3 and funct7.
- Takes the PC redirect (PCSrc/PCTarget) back from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- XLEN, 32, address and instruction width.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_req  output  1  request valid.
- imem_addr  output  XLEN  word-aligned fetch address.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  XLEN  response instruction word.
- PCSrc  input  1  take PCTarget as the next PC; sampled only on the decode handshake.
- PCTarget  input  XLEN  redirect target.
- instr_valid  output  1  Instr/PC/PCPlus4 are valid.
- instr_ready  input  1  decode accepts this cycle.
- Instr  output  XLEN  fetched instruction.
- PC  output  XLEN  address of Instr.
- PCPlus4  output  XLEN  PC + 4.

Behaviour:
- Reset (rst=0, asynchronous) forces the following, regardless of state or outstanding request:
  - state=IDLE, pc_q=RESET_PC, Instr=32'h0000_0013 (NOP), imem_req=0, instr_valid=0.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=pc_q. Hold both stable until imem_gnt=1, then go to WAIT.
  - WAIT: await imem_rvalid=1. On rvalid, latch imem_rdata into Instr and go to HOLD.
  - HOLD: instr_valid=1; Instr/PC/PCPlus4 held stable.
- Handshake in HOLD (instr_valid & instr_ready):
  - pc_q <= PCSrc ? {PCTarget[XLEN-1:2],2'b00} : pc_q+4.
  - Go directly to REQ: next request issues the following cycle.
- Throughput and latency:
  - Exactly one outstanding request.
  - Minimum 3 cycles per instruction: gnt in the REQ cycle, rvalid the cycle after gnt, ready in the first HOLD cycle.
- imem_rvalid:
  - Accepted only in WAIT; ignored in all other states, including a late response arriving after reset.
  - rvalid in the same cycle as gnt is a protocol violation and is ignored.
- Redirect:
  - PCSrc/PCTarget are ignored outside the handshake cycle. No flush is needed because no request is in flight during HOLD.
  - Misaligned PCTarget: low 2 bits are cleared silently.
- Arithmetic:
  - PCPlus4 = PC + 4, modulo 2^XLEN. PC 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Back-pressure: instr_ready=0 keeps HOLD indefinitely with all outputs stable.
- Outputs are registered; there is no combinational path from instr_ready to imem_req.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each decode handshake.
  - stall_cnt increments each cycle in REQ with imem_gnt=0, each cycle in WAIT with imem_rvalid=0, and each cycle in HOLD with instr_ready=0.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg:
  - fetch state encoding: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3.
  - NOP_INSTR=32'h0000_0013.
  - RESET_PC default.
- Sub-module pc_reg: PC register with async active-low reset, load enable and next-PC mux (PC+4 / aligned target).
- FSM and instruction latch stay in the top.

Test Plan:
- Reset: rst=0 → imem_req=0, instr_valid=0, Instr=32'h13. Release → IDLE one cycle, then imem_req=1 with imem_addr=0.
- Zero-wait memory, instr_ready=1: fetch 3 words (32'h00500093, 32'h00a00113, 32'h002081b3) → PC sequence 0,4,8; one instr_valid pulse every 3 cycles.
- Stalls: gnt held low 4 cycles, rvalid delayed 2 cycles, ready low 5 cycles → imem_addr and Instr stable throughout; stall_cnt=11 with IFU_PERF_CNT_EN.
- Redirect: on the handshake with PC=8, PCSrc=1, PCTarget=32'h0000_0043 → next imem_addr=32'h40. PCSrc pulsed while in WAIT → ignored.
- Wrap: RESET_PC=32'hFFFF_FFFC → PCPlus4=0; next fetch address 0.
- Reset mid-operation: rst=0 in WAIT, then a late rvalid with 32'hDEADBEEF after release → ignored; refetch from RESET_PC.
